// File: rtl/dmem_responder_pkg.sv
// Shared types for the MEM-stage data-memory responder: FSM encoding,
// word geometry and the latched request record.
package dmem_responder_pkg;

  localparam int WORD_BYTES = 4;
  localparam int WORD_BITS  = WORD_BYTES * 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic                  we;
    logic [31:0]           addr;
    logic [WORD_BITS-1:0]  wdata;
    logic [WORD_BYTES-1:0] be;
  } req_t;

endpackage

// File: rtl/dmem_ram_1rw1r.sv
// Word RAM: one byte-enabled write port, two synchronous read ports.
// A read of the word being written on the same edge returns the old contents.
module dmem_ram_1rw1r
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [WORD_BITS-1:0]  wdata,
  input  logic [WORD_BYTES-1:0] be,
  input  logic                  a_en,
  input  logic                  a_zero,
  input  logic [AW-1:0]         a_addr,
  output logic [WORD_BITS-1:0]  a_data,
  input  logic [AW-1:0]         b_addr,
  output logic [WORD_BITS-1:0]  b_data
);

  logic [WORD_BYTES-1:0][7:0] mem [DEPTH];

  // Storage is never reset; only the read registers are.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (be[i]) mem[waddr][i] <= wdata[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_data <= '0;
      b_data <= '0;
    end else begin
      if (a_en) a_data <= a_zero ? '0 : mem[a_addr];
      b_data <= mem[b_addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage load/store responder: accepts one request, waits WAIT_STATES
// cycles while stalling the pipeline, then performs the access and pulses resp_valid.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter  int DEPTH_WORDS = 256,
  parameter  int WAIT_STATES = 2,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  input  logic [31:0] dbg_addr,
  output logic [31:0] dbg_data
);

  localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_e     state;
  logic [3:0] cnt;
  req_t       req_q;
  req_t       live;
  req_t       acc;
  logic       acc_err;
  logic       commit;
  logic       unused_dbg;

  assign live = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};

  // With zero wait states the access happens on the acceptance edge, so it
  // must use the live request rather than the latched copy.
  assign acc     = (state == IDLE) ? live : req_q;
  assign acc_err = (acc.addr[1:0] != 2'b00) || ((acc.addr >> (AW + 2)) != 32'd0);
  assign commit  = rst_n &&
                   (((state == IDLE) && req_valid && (WAIT_STATES == 0)) ||
                    ((state == WAIT) && (cnt == 4'd0)));

  assign stall = ((state == IDLE) && req_valid) || (state == WAIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      req_q      <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_q <= live;
            if (WAIT_STATES == 0) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= acc_err;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= acc_err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  dmem_ram_1rw1r #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (commit && acc.we && !acc_err),
    .waddr  (acc.addr[AW+1:2]),
    .wdata  (acc.wdata),
    .be     (acc.be),
    .a_en   (commit),
    .a_zero (acc.we || acc_err),
    .a_addr (acc.addr[AW+1:2]),
    .a_data (resp_rdata),
    .b_addr (dbg_addr[AW+1:2]),
    .b_data (dbg_data)
  );

  // Debug address bits outside the word index are deliberately ignored.
  assign unused_dbg = ^{dbg_addr[31:AW+2], dbg_addr[1:0]};

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with 2 wait states, one with 0.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata, dbg_addr;
  logic [3:0]  req_be;
  logic        stall, resp_valid, resp_err;
  logic [31:0] resp_rdata, dbg_data;

  logic        z_req_valid, z_req_we;
  logic [31:0] z_req_addr, z_req_wdata;
  logic [3:0]  z_req_be;
  logic        z_stall, z_resp_valid, z_resp_err;
  logic [31:0] z_resp_rdata, z_dbg_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be),
    .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(z_req_valid), .req_we(z_req_we), .req_addr(z_req_addr),
    .req_wdata(z_req_wdata), .req_be(z_req_be),
    .stall(z_stall), .resp_valid(z_resp_valid), .resp_rdata(z_resp_rdata),
    .resp_err(z_resp_err), .dbg_addr(32'h0), .dbg_data(z_dbg_data)
  );

  // Drive one request on dut, holding it while stall is high like the pipeline does.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output int nstall, output int lat,
                       output logic [31:0] rd, output logic er);
    nstall = 0; lat = -1; rd = 'x; er = 'x;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    for (int n = 0; n < 12 && lat < 0; n++) begin
      #1;
      if (stall) nstall++;
      if (resp_valid) begin lat = n; rd = resp_rdata; er = resp_err; end
      if (!stall) req_valid = 1'b0;
      if (lat < 0) @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_be = 0; dbg_addr = 0;
    z_req_valid = 0; z_req_we = 0; z_req_addr = 0; z_req_wdata = 0; z_req_be = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({stall, resp_valid, resp_err} !== 3'b000) begin n_bad++;
      $display("FAIL reset_ctl: got %b want 000", {stall, resp_valid, resp_err}); end
    n_cmp++; if (resp_rdata !== 32'h0) begin n_bad++;
      $display("FAIL reset_rdata: got %h want 0", resp_rdata); end
    n_cmp++; if (dbg_data !== 32'h0) begin n_bad++;
      $display("FAIL reset_dbg: got %h want 0", dbg_data); end
    n_cmp++; if ({z_stall, z_resp_valid, z_resp_err, z_resp_rdata} !== 35'h0) begin n_bad++;
      $display("FAIL reset_dut0: got %b %b %b %h want all 0", z_stall, z_resp_valid, z_resp_err, z_resp_rdata); end
    rst_n = 1'b1;
  endtask

  task automatic test_store_load();
    int ns, lat; logic [31:0] rd; logic er;
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, ns, lat, rd, er);
    n_cmp++; if (ns !== 3) begin n_bad++; $display("FAIL store_stall_cycles: got %0d want 3", ns); end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL store_latency: got %0d want 3", lat); end
    n_cmp++; if ({er, rd} !== 33'h0) begin n_bad++; $display("FAIL store_resp: err %b rdata %h want 0 0", er, rd); end
    issue(1'b0, 32'h10, 32'h0, 4'h0, ns, lat, rd, er);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL load_latency: got %0d want 3", lat); end
    n_cmp++; if ({er, rd} !== {1'b0, 32'hDEADBEEF}) begin n_bad++;
      $display("FAIL load_data: err %b rdata %h want 0 deadbeef", er, rd); end
  endtask

  task automatic test_byte_enable();
    int ns, lat; logic [31:0] rd; logic er;
    issue(1'b1, 32'h10, 32'h000000AA, 4'b0001, ns, lat, rd, er);
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL be_store_err: got %b want 0", er); end
    issue(1'b0, 32'h10, 32'h0, 4'h0, ns, lat, rd, er);
    n_cmp++; if (rd !== 32'hDEADBEAA) begin n_bad++; $display("FAIL be_merge: got %h want deadbeaa", rd); end
    issue(1'b1, 32'h10, 32'h12345678, 4'b0000, ns, lat, rd, er);
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL be0_err: got %b want 0", er); end
    issue(1'b0, 32'h10, 32'h0, 4'h0, ns, lat, rd, er);
    n_cmp++; if (rd !== 32'hDEADBEAA) begin n_bad++; $display("FAIL be0_nochange: got %h want deadbeaa", rd); end
  endtask

  task automatic test_errors();
    int ns, lat; logic [31:0] rd; logic er;
    issue(1'b0, 32'h13, 32'h0, 4'h0, ns, lat, rd, er);
    n_cmp++; if ({lat, er, rd} !== {32'd3, 1'b1, 32'h0}) begin n_bad++;
      $display("FAIL err_misaligned: lat %0d err %b rdata %h want 3 1 0", lat, er, rd); end
    issue(1'b0, 32'h400, 32'h0, 4'h0, ns, lat, rd, er);
    n_cmp++; if ({lat, er, rd} !== {32'd3, 1'b1, 32'h0}) begin n_bad++;
      $display("FAIL err_range: lat %0d err %b rdata %h want 3 1 0", lat, er, rd); end
    // 0x410 aliases word 4 (0x10) if the range check were missing
    issue(1'b1, 32'h410, 32'h12345678, 4'hF, ns, lat, rd, er);
    n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL err_store_range: got %b want 1", er); end
    issue(1'b1, 32'h11, 32'h12345678, 4'hF, ns, lat, rd, er);
    n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL err_store_misaligned: got %b want 1", er); end
    issue(1'b0, 32'h10, 32'h0, 4'h0, ns, lat, rd, er);
    n_cmp++; if ({er, rd} !== {1'b0, 32'hDEADBEAA}) begin n_bad++;
      $display("FAIL err_ram_unchanged: err %b rdata %h want 0 deadbeaa", er, rd); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] st, rv;
    logic [31:0] rd3, rd5;
    st = '0; rv = '0; rd3 = 'x; rd5 = 'x;
    @(negedge clk);
    z_req_valid = 1'b1; z_req_we = 1'b1; z_req_addr = 32'h8; z_req_wdata = 32'hCAFEF00D; z_req_be = 4'hF;
    for (int n = 0; n < 6; n++) begin
      #1;
      st[n] = z_stall; rv[n] = z_resp_valid;
      if (n == 3) rd3 = z_resp_rdata;
      if (n == 5) rd5 = z_resp_rdata;
      // pipeline advances in RESP; the next request (a held load) appears immediately
      if (n == 1) z_req_we = 1'b0;
      if (n < 5) @(negedge clk);
    end
    z_req_valid = 1'b0;
    n_cmp++; if (st !== 6'b010101) begin n_bad++; $display("FAIL b2b_stall: got %b want 010101", st); end
    n_cmp++; if (rv !== 6'b101010) begin n_bad++; $display("FAIL b2b_resp_valid: got %b want 101010", rv); end
    n_cmp++; if (rd3 !== 32'hCAFEF00D) begin n_bad++; $display("FAIL b2b_load1: got %h want cafef00d", rd3); end
    n_cmp++; if (rd5 !== 32'hCAFEF00D) begin n_bad++; $display("FAIL b2b_load2: got %h want cafef00d", rd5); end
  endtask

  task automatic test_dbg_collision();
    int ns, lat; logic [31:0] rd; logic er;
    issue(1'b1, 32'h20, 32'h11111111, 4'hF, ns, lat, rd, er);
    @(negedge clk);
    dbg_addr = 32'h24;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h22222222; req_be = 4'hF;
    @(negedge clk);
    @(negedge clk);
    dbg_addr = 32'h20;
    @(negedge clk);
    #1;
    req_valid = 1'b0;
    n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL dbg_commit_edge: resp_valid %b want 1", resp_valid); end
    n_cmp++; if (dbg_data !== 32'h11111111) begin n_bad++; $display("FAIL dbg_old_word: got %h want 11111111", dbg_data); end
    @(negedge clk);
    n_cmp++; if (dbg_data !== 32'h22222222) begin n_bad++; $display("FAIL dbg_new_word: got %h want 22222222", dbg_data); end
    dbg_addr = 32'hFFFFFC13;
    @(negedge clk);
    n_cmp++; if (dbg_data !== 32'hDEADBEAA) begin n_bad++; $display("FAIL dbg_ignore_bits: got %h want deadbeaa", dbg_data); end
  endtask

  task automatic test_reset_mid_op();
    int ns, lat; logic [31:0] rd; logic er;
    logic seen_rv;
    seen_rv = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h55555555; req_be = 4'hF;
    @(negedge clk);
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL midrst_in_wait: stall %b want 1", stall); end
    rst_n = 1'b0;
    req_valid = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (resp_valid) seen_rv = 1'b1;
      if (n == 1) rst_n = 1'b1;
    end
    n_cmp++; if (seen_rv !== 1'b0) begin n_bad++; $display("FAIL midrst_no_resp: resp_valid seen %b want 0", seen_rv); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL midrst_stall: got %b want 0", stall); end
    issue(1'b0, 32'h10, 32'h0, 4'h0, ns, lat, rd, er);
    n_cmp++; if (rd !== 32'hDEADBEAA) begin n_bad++; $display("FAIL midrst_ram_kept: got %h want deadbeaa", rd); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store_load();
    test_byte_enable();
    test_errors();
    test_back_to_back();
    test_dbg_collision();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving the pipeline's MEM-stage load/store requests (word address, write data, read/write strobes).
- Owns a word-organised RAM, inserts a configurable number of wait states and drives a stall back to the pipeline until each access completes.
- Adds a byte-enable write path and a registered side debug read port that feeds the top-level data/address observation outputs.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words; must be a power of two.
WAIT_STATES, 2, extra cycles between acceptance and response; 0..15.
AW, $clog2(DEPTH_WORDS), word-index width (derived; do not override).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
req_valid  input  1  MEM stage has a load or store pending
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data
req_be  input  4  byte enables; bit i covers wdata[8i+7:8i]
stall  output  1  pipeline hold request
resp_valid  output  1  one-cycle response strobe
resp_rdata  output  32  load data; valid only with resp_valid
resp_err  output  1  access error; valid only with resp_valid
dbg_addr  input  32  debug byte address
dbg_data  output  32  debug read data, one cycle after dbg_addr

Behaviour:
- Reset: synchronous to clk, active-low (rst_n=0 sampled at a rising edge). State goes to IDLE; counter=0; stall, resp_valid, resp_err = 0; resp_rdata = 0; dbg_data = 0. RAM contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE, req_valid=1: accept. Latch we/addr/wdata/be. Go to WAIT with counter=WAIT_STATES-1, or directly to RESP if WAIT_STATES=0. Request inputs are ignored after acceptance.
- WAIT: decrement counter. At counter=0, perform the access and go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE unconditionally. A request visible during RESP is the one just served and is not re-accepted.
- Latency: resp_valid is high exactly WAIT_STATES+1 cycles after the acceptance edge.
- stall = (state==IDLE & req_valid) | state==WAIT. It is combinational and low in RESP, so the pipeline advances on the RESP edge.
- Access timing: the access occurs on the edge entering RESP. Loads register resp_rdata on that edge. Stores write only the bytes with be set. resp_rdata is 0 for stores.
- Error: resp_err=1 if addr[1:0]!=0, or if addr[31:2] >= DEPTH_WORDS (any bit above AW+1 set). On error there is no write and resp_rdata=0. The latency is unchanged.
- be=0000 on a store: no RAM change, resp_err=0.
- Debug port: dbg_data <= RAM[dbg_addr[AW+1:2]] every cycle (one-cycle latency). Upper and low address bits are ignored.
  - Same-edge collision with a store to the same word: dbg_data returns the old word (read-before-write).
- Reset mid-operation: a store not yet committed (still in WAIT) is dropped. No resp_valid is produced for it.
- Back-to-back: the earliest next acceptance is the cycle after RESP. Throughput is one access per WAIT_STATES+2 cycles.

Decomposition:
- Shared package: FSM state enum (IDLE/WAIT/RESP, 2-bit) and localparam WORD_BYTES=4.
- Sub-module dmem_ram_1rw1r: a single write port with byte enables, two synchronous read ports, read-before-write on collision. The FSM, counter and error check stay in dmem_responder.

Test Plan:
- Reset, then store 0xDEADBEEF to 0x10 with be=1111, WAIT_STATES=2 -> stall high 3 cycles; resp_valid on the 3rd cycle after acceptance with err=0; then load 0x10 -> resp_rdata=0xDEADBEEF.
- Store 0x000000AA to 0x10 with be=0001 over 0xDEADBEEF -> subsequent load returns 0xDEADBEAA.
- Load from 0x13 and from 0x400 (DEPTH_WORDS=256) -> resp_err=1, rdata=0, RAM unchanged, latency still 3.
- WAIT_STATES=0: two back-to-back loads held by the pipeline -> resp_valid pulses 2 cycles apart; stall high only in each acceptance cycle.
- dbg_addr=0x20 on the same edge as a store committing to 0x20 (old 0x11111111, new 0x22222222) -> dbg_data=0x11111111, then 0x22222222 the next cycle.
- Store accepted, rst_n=0 during WAIT -> no resp_valid; stall=0 after reset; RAM word keeps its old value.
